// File: rtl/mem_access_unit_if.sv
// Signal bundle around the memory-access stage: EX-side operation, data-memory
// req/ack port and write-back/status results. The unit uses the slave view.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ex_valid;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic [2:0]            ex_funct3;
  logic [DATA_WIDTH-1:0] ex_addr;
  logic [DATA_WIDTH-1:0] ex_store_data;
  logic [4:0]            ex_rd;
  logic                  stall;
  logic                  dmem_req;
  logic                  dmem_we;
  logic [DATA_WIDTH-1:0] dmem_addr;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  logic                  dmem_ack;
  logic                  wb_valid;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [4:0]            wb_rd;
  logic                  misaligned;
  logic                  timeout_err;

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr,
           ex_store_data, ex_rd, dmem_rdata, dmem_ack,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           wb_valid, wb_data, wb_rd, misaligned, timeout_err
  );

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr,
           ex_store_data, ex_rd, dmem_rdata, dmem_ack,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           wb_valid, wb_data, wb_rd, misaligned, timeout_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage: one load/store per transaction over a req/ack port,
// lane alignment and extension of loads, misalignment and timeout reporting.
module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rstN,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [4:0]            rd_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  stall_q;
  logic                  req_q;
  logic                  wb_valid_q;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic                  mis_q, mis_d;
  logic                  to_q, to_d;
  logic                  load_s;
  logic                  accept_s;
  logic                  misal_s;
  logic [3:0]            be_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [DATA_WIDTH-1:0] lane_s;
  logic [DATA_WIDTH-1:0] ext_s;

  assign accept_s = bus.ex_valid & (bus.ex_mem_read | bus.ex_mem_write);

  // Width decode: alignment legality, byte enables and lane-replicated store data
  always_comb begin
    misal_s = 1'b0;
    be_s    = 4'b0000;
    wdata_s = bus.ex_store_data;
    case (bus.ex_funct3)
      3'b000, 3'b100: begin
        be_s    = 4'b0001 << bus.ex_addr[1:0];
        wdata_s = {4{bus.ex_store_data[7:0]}};
      end
      3'b001, 3'b101: begin
        misal_s = bus.ex_addr[0];
        be_s    = 4'b0011 << bus.ex_addr[1:0];
        wdata_s = {2{bus.ex_store_data[15:0]}};
      end
      3'b010: begin
        misal_s = (bus.ex_addr[1:0] != 2'b00);
        be_s    = 4'b1111;
      end
      default: misal_s = 1'b1;
    endcase
  end

  // Load extraction: shift the addressed lane down, then sign/zero extend
  always_comb begin
    lane_s = bus.dmem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ext_s = {{(DATA_WIDTH-8){lane_s[7]}}, lane_s[7:0]};
      3'b001:  ext_s = {{(DATA_WIDTH-16){lane_s[15]}}, lane_s[15:0]};
      3'b100:  ext_s = {{(DATA_WIDTH-8){1'b0}}, lane_s[7:0]};
      3'b101:  ext_s = {{(DATA_WIDTH-16){1'b0}}, lane_s[15:0]};
      3'b010:  ext_s = lane_s;
      default: ext_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Next-state logic; an ack in the expiry cycle takes priority over timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    mis_d     = 1'b0;
    to_d      = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (accept_s) begin
          if (misal_s) begin
            mis_d = 1'b1;
          end else begin
            load_s  = 1'b1;
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.dmem_ack) begin
          state_d   = RESP;
          wb_data_d = we_q ? {DATA_WIDTH{1'b0}} : ext_s;
          wb_rd_d   = rd_q;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      rd_q       <= 5'd0;
      we_q       <= 1'b0;
      addr_q     <= {DATA_WIDTH{1'b0}};
      be_q       <= 4'b0000;
      wdata_q    <= {DATA_WIDTH{1'b0}};
      stall_q    <= 1'b0;
      req_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= {DATA_WIDTH{1'b0}};
      wb_rd_q    <= 5'd0;
      mis_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stall_q    <= (state_d != IDLE);
      req_q      <= (state_d == REQ);
      wb_valid_q <= (state_d == RESP);
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      mis_q      <= mis_d;
      to_q       <= to_d;
      if (load_s) begin
        funct3_q <= bus.ex_funct3;
        off_q    <= bus.ex_addr[1:0];
        rd_q     <= bus.ex_rd;
        we_q     <= bus.ex_mem_write;
        addr_q   <= {bus.ex_addr[DATA_WIDTH-1:2], 2'b00};
        be_q     <= be_s;
        wdata_q  <= wdata_s;
      end
    end
  end

  assign bus.stall       = stall_q;
  assign bus.dmem_req    = req_q;
  assign bus.dmem_we     = we_q;
  assign bus.dmem_addr   = addr_q;
  assign bus.dmem_be     = be_q;
  assign bus.dmem_wdata  = wdata_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.misaligned  = mis_q;
  assign bus.timeout_err = to_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT_CYCLES=4; expected values
// are hand-computed constants.
module tb_mem_access_unit;

  logic clk;
  logic rstN;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_access_unit_if #(.DATA_WIDTH(32)) bus ();

  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single edge, then withdraw it
  task automatic issue(input logic is_load, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] rd);
    bus.ex_valid      = 1'b1;
    bus.ex_mem_read   = is_load;
    bus.ex_mem_write  = ~is_load;
    bus.ex_funct3     = f3;
    bus.ex_addr       = addr;
    bus.ex_store_data = sd;
    bus.ex_rd         = rd;
    tick();
    bus.ex_valid     = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_mem_write = 1'b0;
  endtask

  task automatic ack_with(input logic [31:0] rdata);
    bus.dmem_rdata = rdata;
    bus.dmem_ack   = 1'b1;
    tick();
    bus.dmem_ack   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    check({tag, "_req"}, {31'd0, bus.dmem_req}, 32'd0);
    check({tag, "_addr"}, bus.dmem_addr, 32'd0);
    check({tag, "_be"}, {28'd0, bus.dmem_be}, 32'd0);
    check({tag, "_wdata"}, bus.dmem_wdata, 32'd0);
    check({tag, "_wbv"}, {31'd0, bus.wb_valid}, 32'd0);
    check({tag, "_wbd"}, bus.wb_data, 32'd0);
    check({tag, "_mis"}, {31'd0, bus.misaligned}, 32'd0);
    check({tag, "_to"}, {31'd0, bus.timeout_err}, 32'd0);
  endtask

  initial begin
    rstN              = 1'b0;
    bus.ex_valid      = 1'b1;
    bus.ex_mem_read   = 1'b1;
    bus.ex_mem_write  = 1'b0;
    bus.ex_funct3     = 3'($urandom_range(0, 7));
    bus.ex_addr       = $urandom;
    bus.ex_store_data = $urandom;
    bus.ex_rd         = 5'($urandom_range(0, 31));
    bus.dmem_rdata    = $urandom;
    bus.dmem_ack      = 1'b1;
    #3;
    check_all_zero("rst");
    bus.ex_valid   = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.dmem_ack   = 1'b0;
    #9 rstN = 1'b1;
    tick();
    check("rel_stall", {31'd0, bus.stall}, 32'd0);
    check("rel_req", {31'd0, bus.dmem_req}, 32'd0);

    // LB 0x1003, ack after 3 wait cycles (lands on the expiry cycle and must win)
    issue(1'b1, 3'b000, 32'h0000_1003, 32'h0, 5'd5);
    check("lb_stall", {31'd0, bus.stall}, 32'd1);
    check("lb_req", {31'd0, bus.dmem_req}, 32'd1);
    check("lb_addr", bus.dmem_addr, 32'h0000_1000);
    check("lb_be", {28'd0, bus.dmem_be}, 32'h8);
    check("lb_we", {31'd0, bus.dmem_we}, 32'd0);
    bus.ex_valid = 1'b1; bus.ex_mem_write = 1'b1; bus.ex_addr = 32'h0000_5554;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lb_wait_req", {31'd0, bus.dmem_req}, 32'd1);
    end
    check("lb_hold_addr", bus.dmem_addr, 32'h0000_1000);
    bus.ex_valid = 1'b0; bus.ex_mem_write = 1'b0;
    ack_with(32'h80FF_1234);
    check("lb_wbv", {31'd0, bus.wb_valid}, 32'd1);
    check("lb_wbd", bus.wb_data, 32'hFFFF_FF80);
    check("lb_rd", {27'd0, bus.wb_rd}, 32'd5);
    check("lb_resp_stall", {31'd0, bus.stall}, 32'd1);
    check("lb_resp_req", {31'd0, bus.dmem_req}, 32'd0);
    check("lb_no_to", {31'd0, bus.timeout_err}, 32'd0);
    tick();
    check("lb_wbv_end", {31'd0, bus.wb_valid}, 32'd0);
    check("lb_idle_stall", {31'd0, bus.stall}, 32'd0);

    // LHU 0x2002 with immediate ack
    issue(1'b1, 3'b101, 32'h0000_2002, 32'h0, 5'd7);
    check("lhu_be", {28'd0, bus.dmem_be}, 32'hC);
    check("lhu_wbv_early", {31'd0, bus.wb_valid}, 32'd0);
    ack_with(32'hBEEF_0000);
    check("lhu_wbv", {31'd0, bus.wb_valid}, 32'd1);
    check("lhu_wbd", bus.wb_data, 32'h0000_BEEF);
    check("lhu_rd", {27'd0, bus.wb_rd}, 32'd7);
    tick();

    // SB 0x10
    issue(1'b0, 3'b000, 32'h0000_0010, 32'h1234_56AB, 5'd0);
    check("sb_be", {28'd0, bus.dmem_be}, 32'h1);
    check("sb_wdata", bus.dmem_wdata, 32'hABAB_ABAB);
    check("sb_we", {31'd0, bus.dmem_we}, 32'd1);
    ack_with(32'hDEAD_BEEF);
    check("sb_wbv", {31'd0, bus.wb_valid}, 32'd1);
    check("sb_wbd", bus.wb_data, 32'd0);
    tick();

    // SH 0x12
    issue(1'b0, 3'b001, 32'h0000_0012, 32'h1234_56AB, 5'd0);
    check("sh_be", {28'd0, bus.dmem_be}, 32'hC);
    check("sh_wdata", bus.dmem_wdata, 32'h56AB_56AB);
    check("sh_addr", bus.dmem_addr, 32'h0000_0010);
    ack_with(32'h0);
    tick();

    // Misaligned LW, misaligned SH, undefined funct3
    issue(1'b1, 3'b010, 32'h0000_1001, 32'h0, 5'd1);
    check("mis_lw", {31'd0, bus.misaligned}, 32'd1);
    check("mis_lw_stall", {31'd0, bus.stall}, 32'd0);
    check("mis_lw_req", {31'd0, bus.dmem_req}, 32'd0);
    tick();
    check("mis_lw_end", {31'd0, bus.misaligned}, 32'd0);
    issue(1'b0, 3'b001, 32'h0000_0003, 32'h0, 5'd1);
    check("mis_sh", {31'd0, bus.misaligned}, 32'd1);
    check("mis_sh_req", {31'd0, bus.dmem_req}, 32'd0);
    tick();
    check("mis_sh_stall", {31'd0, bus.stall}, 32'd0);
    issue(1'b1, 3'b011, 32'h0000_0000, 32'h0, 5'd1);
    check("mis_f3", {31'd0, bus.misaligned}, 32'd1);
    tick();

    // Timeout after 4 REQ cycles, then a late ack
    issue(1'b1, 3'b010, 32'h0000_0040, 32'h0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait_req", {31'd0, bus.dmem_req}, 32'd1);
    end
    tick();
    check("to_pulse", {31'd0, bus.timeout_err}, 32'd1);
    check("to_stall", {31'd0, bus.stall}, 32'd0);
    check("to_req", {31'd0, bus.dmem_req}, 32'd0);
    check("to_wbv", {31'd0, bus.wb_valid}, 32'd0);
    ack_with(32'h1111_1111);
    check("to_pulse_end", {31'd0, bus.timeout_err}, 32'd0);
    check("late_ack_wbv", {31'd0, bus.wb_valid}, 32'd0);
    check("late_ack_stall", {31'd0, bus.stall}, 32'd0);

    // Reset abort during REQ
    issue(1'b1, 3'b010, 32'h0000_0080, 32'h0, 5'd3);
    check("ab_req_pre", {31'd0, bus.dmem_req}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    check_all_zero("ab");
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    #2 rstN = 1'b1;
    tick();
    ack_with(32'h2222_2222);
    check("ab_wbv", {31'd0, bus.wb_valid}, 32'd0);
    check("ab_stall", {31'd0, bus.stall}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("ab_no_to", {31'd0, bus.timeout_err}, 32'd0);
    check("ab_no_wbv", {31'd0, bus.wb_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage sitting directly downstream of the EXECUTE-stage ALU. It takes the ALU result as an effective address, plus store data and access width. It runs one load or store over a variable-latency req/ack data-memory port, then hands an aligned, sign- or zero-extended result to write-back. The unit stalls the upstream pipeline while a transaction is outstanding and flags misaligned accesses and memory timeouts.

## Interface
- DATA_WIDTH, 32: data and address width; only 32 is supported.
- TIMEOUT_CYCLES, 255: maximum number of cycles to wait for dmem_ack; legal range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- rstN  in  1  reset; one clock, asynchronous assertion, active-low.
- ex_valid  in  1  EX presents a memory operation this cycle.
- ex_mem_read  in  1  operation is a load.
- ex_mem_write  in  1  operation is a store. At most one of read/write is high.
- ex_funct3  in  3  access width: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ex_addr  in  DATA_WIDTH  effective address (ALU out).
- ex_store_data  in  DATA_WIDTH  store data (rs2), LSB-justified.
- ex_rd  in  5  destination register tag.
- stall  out  1  high whenever state != IDLE.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DATA_WIDTH  word address: ex_addr with bits [1:0] forced to 00.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data.
- dmem_rdata  in  DATA_WIDTH  read word; valid when dmem_ack is high.
- dmem_ack  in  1  one-cycle completion pulse.
- wb_valid  out  1  one-cycle result pulse.
- wb_data  out  DATA_WIDTH  extended load data; 0 for stores.
- wb_rd  out  5  tag of the completed operation.
- misaligned  out  1  one-cycle pulse: operation rejected.
- timeout_err  out  1  one-cycle pulse: no ack within TIMEOUT_CYCLES.

## Operation
**Reset.** Every output and every register goes to 0. The FSM enters IDLE.

**FSM states:** IDLE, REQ, RESP.

**IDLE.**
- An operation is accepted when ex_valid & (ex_mem_read | ex_mem_write).
- On acceptance the unit latches addr, funct3, store data, rd and we.
- Alignment check:
  - halfword: addr[0] must be 0;
  - word: addr[1:0] must be 00.
- Misaligned operations and undefined funct3 codes (011, 110, 111):
  - pulse misaligned next cycle;
  - no memory request is issued;
  - remain in IDLE.
- Aligned operations go to REQ.

**REQ.**
- dmem_req is held high, and all dmem_* outputs are held stable, until dmem_ack.
- On dmem_ack:
  - latch the extended rdata (loads);
  - go to RESP.
- A wait counter starts at 0 on entry and increments every REQ cycle without ack. If it reaches TIMEOUT_CYCLES:
  - drop dmem_req;
  - pulse timeout_err;
  - return to IDLE with no wb_valid.
- An ack arriving in the same cycle the counter would expire wins.

**RESP.**
- wb_valid=1 for exactly one cycle, with wb_data and wb_rd.
- Return to IDLE.

**Byte enables**, with o = addr[1:0]:
- byte: 0001 << o;
- half: 0011 << o;
- word: 1111.

**Store data lanes:**
- byte: store_data[7:0] replicated ×4;
- half: store_data[15:0] replicated ×2;
- word: unchanged.

**Load extraction.**
- The selected lane is rdata >> (8·o).
- Signed loads (LB/LH): sign-extend from bit 7 or bit 15.
- LBU/LHU: zero-extend.
- LW: unchanged.

**Other rules.**
- A dmem_ack outside REQ is ignored.
- ex_* inputs are ignored while state != IDLE. Upstream holds them under stall.
- Asserting rstN low mid-transaction aborts it immediately:
  - dmem_req drops asynchronously;
  - no wb_valid or error pulse follows.

## Timing
- Accept at edge E0. stall and dmem_req are high from E0 until the ack edge.
- With ack sampled at edge E1, wb_valid is high during the cycle after E1, and stall is still high in that cycle. The unit is back in IDLE after E2.
- Minimum latency: ack in the first REQ cycle gives accept→wb_valid = 2 cycles. Throughput is one operation per 3 cycles minimum.
- misaligned pulses in the cycle after acceptance. stall never rises for a misaligned operation.
- timeout_err is asserted in the cycle after the expiry edge; stall drops in the same cycle.
- All outputs are registered; there is no combinational path from dmem_ack or ex_* to any output.

## Test plan
- **Reset.** Drive rstN=0 mid-cycle with random inputs → all outputs 0 immediately. Release rstN → stall=0, dmem_req=0.
- **Byte load, sign-extended.**
  - Stimulus: LB, addr 0x1003, rd=5; dmem_rdata=0x80FF_1234 with ack after 3 wait cycles.
  - Required: dmem_addr=0x1000, be=1000, wb_data=0xFFFF_FF80, wb_rd=5, wb_valid for exactly 1 cycle.
- **Halfword load, zero-extended.** LHU, addr 0x2002, rdata=0xBEEF_0000, immediate ack → wb_data=0x0000_BEEF, wb_valid 2 cycles after accept.
- **Store lanes.**
  - SB, addr 0x10, store_data=0x1234_56AB → be=0001, wdata=0xABAB_ABAB, we=1, wb_data=0.
  - SH, addr 0x12 → be=1100, wdata=0x56AB_56AB.
- **Misaligned.** LW at 0x1001, then SH at 0x3 → misaligned pulses twice, dmem_req never asserted, stall stays 0.
- **Timeout and reset abort.**
  - TIMEOUT_CYCLES=4, ack never arrives → timeout_err pulse after 4 REQ cycles, no wb_valid.
  - Repeat with rstN low during REQ → req drops at once, no pulses.
  - A late ack after reset or timeout is ignored.
